dsc_mul_seq: RTL and testbench

Operand sequencer and result capture stage that sits directly around the 2-input 8b deterministic stochastic multiplier. It accepts operand pairs over a valid/ready handshake and drives the multiplier's operand, enable and clear inputs. It watches the multiplier's early-shutoff/overflow flag, captures the 16b binary product and a run-length count, and presents them downstream over a second valid/ready handshake.

---
 rtl/dsc_mul_seq.sv | 183 ++++++++++++++++++
 tb/tb_dsc_mul_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_mul_seq.sv
// ---------------------------------------------------------------------------
// dsc_mul_seq
// Operand sequencer and result capture stage wrapped around the 2-input
// deterministic stochastic multiplier. Operand pairs arrive over a valid/ready
// handshake, get latched onto mul_a/mul_b, the multiplier is cleared for one
// cycle, enabled until it flags early-shutoff/overflow (or a timeout expires),
// allowed one idle cycle to settle, and the product plus run length are then
// held on a second valid/ready handshake until downstream takes them.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a, in_b are the operands
//   out_valid/out_ready   result handshake; out_z product, out_cyc RUN cycles
//                         consumed, out_err set when the run timed out
//   mul_a, mul_b          registered operands to the multiplier
//   mul_en, mul_clr       multiplier enable and one-cycle synchronous clear
//   mul_z, mul_ov         multiplier binary product and overflow flag
//   busy                  high whenever the sequencer is not idle
//
// Build option
//   DSC_SEQ_ZERO_BYPASS_EN  when defined, a zero operand skips the multiplier
//                           entirely and reports a zero product in one cycle.
// ---------------------------------------------------------------------------
module dsc_mul_seq #(
  parameter int SNG_WIDTH = 8,
  parameter int OV_MASK   = 2,
  parameter int MAX_CYC   = 65536,
  parameter int CYC_W     = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SNG_WIDTH-1:0]   in_a,
  input  logic [SNG_WIDTH-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*SNG_WIDTH-1:0] out_z,
  output logic [CYC_W-1:0]       out_cyc,
  output logic                   out_err,
  output logic [SNG_WIDTH-1:0]   mul_a,
  output logic [SNG_WIDTH-1:0]   mul_b,
  output logic                   mul_en,
  output logic                   mul_clr,
  input  logic [2*SNG_WIDTH-1:0] mul_z,
  input  logic                   mul_ov,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CYC_W-1:0] OV_MASK_C = CYC_W'(OV_MASK);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYC - 1);

  state_t                 state_q, state_d;
  logic [CYC_W-1:0]       cnt_q, cnt_d;
  logic [CYC_W-1:0]       cnt_inc;
  logic                   err_q, err_d;
  logic [SNG_WIDTH-1:0]   a_q, a_d;
  logic [SNG_WIDTH-1:0]   b_q, b_d;
  logic [2*SNG_WIDTH-1:0] z_q, z_d;
  logic [CYC_W-1:0]       ocyc_q, ocyc_d;
  logic                   oerr_q, oerr_d;
  logic                   in_ready_q, out_valid_q, mul_en_q, mul_clr_q, busy_q;

  // The count includes the RUN cycle being evaluated, so the mask window and
  // the timeout compare against the value that would be stored this cycle.
  // The timeout exit fires at MAX_CYC-1, so the counter can never wrap.
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state logic. Datapath registers hold by default; the status outputs
  // are derived from state_d below so that they are registered yet always
  // line up with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    ocyc_d  = ocyc_q;
    oerr_d  = oerr_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CLEAR;
`ifdef DSC_SEQ_ZERO_BYPASS_EN
          if ((in_a == '0) || (in_b == '0)) begin
            z_d     = '0;
            ocyc_d  = '0;
            oerr_d  = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end
      CLEAR: begin
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        // mul_ov outranks the timeout when both land in the same cycle.
        if ((cnt_inc >= OV_MASK_C) && mul_ov) begin
          err_d   = 1'b0;
          state_d = DRAIN;
        end else if (cnt_inc == CYC_LAST) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // mul_en has dropped, so mul_z is final by the end of this cycle.
        z_d     = mul_z;
        ocyc_d  = cnt_q;
        oerr_d  = err_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      ocyc_q      <= '0;
      oerr_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mul_en_q    <= 1'b0;
      mul_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      ocyc_q      <= ocyc_d;
      oerr_q      <= oerr_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      mul_en_q    <= (state_d == RUN);
      mul_clr_q   <= (state_d == CLEAR);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_z     = z_q;
  assign out_cyc   = ocyc_q;
  assign out_err   = oerr_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign mul_en    = mul_en_q;
  assign mul_clr   = mul_clr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_dsc_mul_seq
// Bench for dsc_mul_seq. A behavioural multiplier stands in for the real one:
// once cleared, each enabled cycle adds operand B into the product until A
// additions have been made, after which it raises its overflow flag. The
// result is therefore a*b, and the run length the sequencer should report
// follows from when that flag first appears relative to the mask window.
// A second instance with a short timeout and a dead overflow flag covers the
// timeout exit.
// ---------------------------------------------------------------------------
module tb_dsc_mul_seq;

  localparam int OV_MASK = 2;

  logic        clk;
  logic        rst;
  logic        inValid, inReady;
  logic [7:0]  inA, inB;
  logic        outValid, outReady;
  logic [15:0] outZ;
  logic [16:0] outCyc;
  logic        outErr;
  logic [7:0]  mulA, mulB;
  logic        mulEn, mulClr;
  logic [15:0] mulZ;
  logic        mulOv;
  logic        busy;

  logic        tValid, tReady;
  logic [7:0]  tA, tB;
  logic        tOutValid, tOutReady;
  logic [15:0] tOutZ;
  logic [16:0] tOutCyc;
  logic        tOutErr;
  logic [7:0]  tMulA, tMulB;
  logic        tMulEn, tMulClr;
  logic [15:0] tMulZ;
  logic        tMulOv;
  logic        tBusy;

  int          modK;
  logic [15:0] modZ;

  int checks = 0;
  int fails  = 0;

  dsc_mul_seq #(.SNG_WIDTH(8), .OV_MASK(OV_MASK), .MAX_CYC(65536), .CYC_W(17)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB),
    .out_valid(outValid), .out_ready(outReady),
    .out_z(outZ), .out_cyc(outCyc), .out_err(outErr),
    .mul_a(mulA), .mul_b(mulB), .mul_en(mulEn), .mul_clr(mulClr),
    .mul_z(mulZ), .mul_ov(mulOv), .busy(busy)
  );

  dsc_mul_seq #(.SNG_WIDTH(8), .OV_MASK(OV_MASK), .MAX_CYC(64), .CYC_W(17)) dutTo (
    .clk(clk), .rst(rst),
    .in_valid(tValid), .in_ready(tReady), .in_a(tA), .in_b(tB),
    .out_valid(tOutValid), .out_ready(tOutReady),
    .out_z(tOutZ), .out_cyc(tOutCyc), .out_err(tOutErr),
    .mul_a(tMulA), .mul_b(tMulB), .mul_en(tMulEn), .mul_clr(tMulClr),
    .mul_z(tMulZ), .mul_ov(tMulOv), .busy(tBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural multiplier: repeated addition of B, A times, then overflow.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      modK <= 0;
      modZ <= '0;
    end else if (mulClr) begin
      modK <= 0;
      modZ <= '0;
    end else if (mulEn && (modK < int'(mulA))) begin
      modK <= modK + 1;
      modZ <= modZ + 16'(mulB);
    end
  end

  assign mulZ   = modZ;
  assign mulOv  = (modK >= int'(mulA));
  assign tMulZ  = 16'h1234;
  assign tMulOv = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, watch the run, hold the result for
  // holdLow cycles while offering a rival operand pair, then hand it off.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int holdLow);
    int lat, clrAt, enAt, clrCnt, expCyc, expLat, expZ;
    bit bypass;
    bypass = 1'b0;
`ifdef DSC_SEQ_ZERO_BYPASS_EN
    bypass = (a == 8'd0) || (b == 8'd0);
`endif
    expZ   = int'(a) * int'(b);
    expCyc = bypass ? 0 : (((int'(a) + 1) > OV_MASK) ? int'(a) + 1 : OV_MASK);
    expLat = bypass ? 1 : expCyc + 3;
    $display("[TB] op a=%0d b=%0d hold=%0d", a, b, holdLow);
    checkOutput("in_ready_idle", 32'(inReady), 32'd1);
    inValid  = 1'b1;
    inA      = a;
    inB      = b;
    outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    inA     = 8'($urandom);
    inB     = 8'($urandom);
    checkOutput("mul_a_latched", 32'(mulA), 32'(a));
    checkOutput("mul_b_latched", 32'(mulB), 32'(b));
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    lat = 1; clrAt = -1; enAt = -1; clrCnt = 0;
    while (!outValid && lat < 400) begin
      if (mulClr) begin
        clrCnt++;
        if (clrAt < 0) clrAt = lat;
      end
      if (mulEn && enAt < 0) enAt = lat;
      @(negedge clk);
      lat++;
    end
    checkOutput("out_valid_seen", 32'(outValid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("out_z", 32'(outZ), 32'(expZ));
    checkOutput("out_cyc", 32'(outCyc), 32'(expCyc));
    checkOutput("out_err", 32'(outErr), 32'd0);
    checkOutput("clr_pulses", 32'(clrCnt), bypass ? 32'd0 : 32'd1);
    checkOutput("clr_cycle", 32'(clrAt), bypass ? 32'hFFFF_FFFF : 32'd1);
    checkOutput("en_rise", 32'(enAt), bypass ? 32'hFFFF_FFFF : 32'd2);
    inValid = 1'b1;
    inA     = a ^ 8'h5A;
    inB     = b ^ 8'hA5;
    for (int i = 0; i < holdLow; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(outValid), 32'd1);
      checkOutput("hold_in_ready", 32'(inReady), 32'd0);
      checkOutput("hold_z", 32'(outZ), 32'(expZ));
      checkOutput("hold_cyc", 32'(outCyc), 32'(expCyc));
      checkOutput("hold_err", 32'(outErr), 32'd0);
    end
    checkOutput("hold_mul_a", 32'(mulA), 32'(a));
    inValid  = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("post_hs_valid", 32'(outValid), 32'd0);
    checkOutput("post_hs_in_ready", 32'(inReady), 32'd1);
    checkOutput("post_hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    inValid = 1'b0; inA = '0; inB = '0; outReady = 1'b0;
    tValid = 1'b0; tA = '0; tB = '0; tOutReady = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_out_z", 32'(outZ), 32'd0);
    checkOutput("rst_out_cyc", 32'(outCyc), 32'd0);
    checkOutput("rst_out_err", 32'(outErr), 32'd0);
    checkOutput("rst_mul_en", 32'(mulEn), 32'd0);
    checkOutput("rst_mul_clr", 32'(mulClr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'd128, 8'd128, 0);
    applyStimulus(8'd255, 8'd255, 0);
    applyStimulus(8'd0, 8'd77, 0);
    applyStimulus(8'd77, 8'd0, 1);
    applyStimulus(8'd1, 8'd200, 0);
    applyStimulus(8'd200, 8'd17, 10);
    for (int n = 0; n < 8; n++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)));
    end

    // Timeout exit on the short-timeout instance.
    tValid = 1'b1; tA = 8'd5; tB = 8'd6;
    @(negedge clk);
    tValid = 1'b0;
    lat = 1;
    while (!tOutValid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("to_valid_seen", 32'(tOutValid), 32'd1);
    checkOutput("to_latency", 32'(lat), 32'd66);
    checkOutput("to_err", 32'(tOutErr), 32'd1);
    checkOutput("to_cyc", 32'(tOutCyc), 32'd63);
    checkOutput("to_z", 32'(tOutZ), 32'h1234);
    tOutReady = 1'b1;
    @(negedge clk);
    tOutReady = 1'b0;
    checkOutput("to_in_ready", 32'(tReady), 32'd1);

    // Asynchronous reset in the middle of a long run.
    inValid = 1'b1; inA = 8'd200; inB = 8'd3;
    @(negedge clk);
    inValid = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("mid_run_en", 32'(mulEn), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_in_ready", 32'(inReady), 32'd1);
    checkOutput("arst_out_valid", 32'(outValid), 32'd0);
    checkOutput("arst_mul_en", 32'(mulEn), 32'd0);
    checkOutput("arst_mul_a", 32'(mulA), 32'd0);
    checkOutput("arst_mul_b", 32'(mulB), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_out_z", 32'(outZ), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'd9, 8'd13, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
